routing_initiator_table: RTL

- Parametrised, run-time programmable successor to the fixed per-NI initiator routing LUT.
- Maps a transaction address to a source route (lut_path) and a target ID, using NUM_REGIONS address windows.
- Registered lookup with a valid/ready handshake, a config write port for the table, and a saturating decode-error counter.
- Sits inside the NI initiator between request packetisation and header build.

---
 rtl/routing_initiator_table.sv | 139 +++++++++++++
 1 files changed

// File: rtl/routing_initiator_table.sv
// rtl/routing_initiator_table.sv - programmable address-window routing table for the NI initiator
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   req_valid/req_ready/req_addr   lookup request handshake and address
//   rsp_valid/rsp_ready            registered lookup result handshake
//   lut_path, transaction_target   route and target ID of the matched region (0 on miss)
//   failed_decoding                no enabled region matched
//   cfg_we, cfg_idx, cfg_en,       table entry write port; all fields of entry cfg_idx
//   cfg_base, cfg_limit,           are written together, out-of-range indices are dropped
//   cfg_path, cfg_target
//   err_count, err_clr             saturating failed-lookup counter and its synchronous clear
module routing_initiator_table #(
    parameter int ADDR_WIDTH    = 32,
    parameter int PATH_WIDTH    = 7,
    parameter int TARGET_WIDTH  = 4,
    parameter int NUM_REGIONS   = 4,
    parameter int IDX_WIDTH     = 4,
    parameter logic [ADDR_WIDTH-1:0]   RST_BASE   = 32'h1a000000,
    parameter logic [ADDR_WIDTH-1:0]   RST_LIMIT  = 32'h20000000,
    parameter logic [PATH_WIDTH-1:0]   RST_PATH   = 7'b0000001,
    parameter logic [TARGET_WIDTH-1:0] RST_TARGET = 4'hc,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PATH_WIDTH-1:0]    lut_path,
    output logic [TARGET_WIDTH-1:0]  transaction_target,
    output logic                     failed_decoding,
    input  logic                     cfg_we,
    input  logic [IDX_WIDTH-1:0]     cfg_idx,
    input  logic                     cfg_en,
    input  logic [ADDR_WIDTH-1:0]    cfg_base,
    input  logic [ADDR_WIDTH-1:0]    cfg_limit,
    input  logic [PATH_WIDTH-1:0]    cfg_path,
    input  logic [TARGET_WIDTH-1:0]  cfg_target,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    input  logic                     err_clr
);

    localparam logic [0:0] STATE_EMPTY = 1'b0;
    localparam logic [0:0] STATE_FULL  = 1'b1;

    logic [0:0] state;

    logic [NUM_REGIONS-1:0]  tbl_en;
    logic [ADDR_WIDTH-1:0]   tbl_base   [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]   tbl_limit  [NUM_REGIONS];
    logic [PATH_WIDTH-1:0]   tbl_path   [NUM_REGIONS];
    logic [TARGET_WIDTH-1:0] tbl_target [NUM_REGIONS];

    logic                    hit;
    logic [PATH_WIDTH-1:0]   hit_path;
    logic [TARGET_WIDTH-1:0] hit_target;
    logic                    accept;

    assign rsp_valid = (state == STATE_FULL);
    // Single output register: a new request may enter only if the slot is
    // empty or is being drained in this same cycle.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Scan from the highest index down so the lowest-indexed hit is the last
    // assignment and therefore wins. base >= limit can never satisfy both
    // compares, so empty windows need no special case.
    always_comb begin
        hit        = 1'b0;
        hit_path   = '0;
        hit_target = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (tbl_en[i] && (req_addr >= tbl_base[i]) && (req_addr < tbl_limit[i])) begin
                hit        = 1'b1;
                hit_path   = tbl_path[i];
                hit_target = tbl_target[i];
            end
        end
    end

    // Table storage. Index matching is done per entry so an index beyond
    // NUM_REGIONS simply matches nothing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                tbl_en[i]     <= (i == 0);
                tbl_base[i]   <= (i == 0) ? RST_BASE   : '0;
                tbl_limit[i]  <= (i == 0) ? RST_LIMIT  : '0;
                tbl_path[i]   <= (i == 0) ? RST_PATH   : '0;
                tbl_target[i] <= (i == 0) ? RST_TARGET : '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_idx == IDX_WIDTH'(i)) begin
                    tbl_en[i]     <= cfg_en;
                    tbl_base[i]   <= cfg_base;
                    tbl_limit[i]  <= cfg_limit;
                    tbl_path[i]   <= cfg_path;
                    tbl_target[i] <= cfg_target;
                end
            end
        end
    end

    // Output stage FSM and result register. The result fields only change on
    // an accept, so a stalled result is untouched by later table writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= STATE_EMPTY;
            lut_path           <= '0;
            transaction_target <= '0;
            failed_decoding    <= 1'b0;
        end else begin
            if (accept) begin
                state              <= STATE_FULL;
                lut_path           <= hit_path;
                transaction_target <= hit_target;
                failed_decoding    <= !hit;
            end else if (rsp_ready) begin
                state <= STATE_EMPTY;
            end
        end
    end

    // Saturating miss counter; clear wins over a same-cycle increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && !hit && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end

endmodule
